// File: rtl/id_ex_operand_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage_if
//
// Purpose: groups every signal between the operand-fetch / ID-EX register
// and its neighbours (decode, register file, writeback, branch unit, execute)
// into one bundle.
//
// Modports:
//   slave  - the id_ex_operand_stage itself
//   master - the surrounding pipeline (or a testbench standing in for it)
//
// Handshake: decode offers an instruction with id_valid; the stage accepts it
// on a posedge where id_valid is high and id_stall is low. While id_stall is
// high, decode must hold its PC and IF/ID contents unchanged. ex_hold is the
// execute stage's "not ready" and freezes the ID/EX register. flush is a
// one-cycle kill of the decode slot and is never dropped, even under ex_hold.
// -----------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
    parameter int WORD_LEN = 32,
    parameter int ADDR_LEN = 5
);
    // decode slot
    logic                id_valid;
    logic [WORD_LEN-1:0] id_pc;
    logic [ADDR_LEN-1:0] id_rs;
    logic [ADDR_LEN-1:0] id_rt;
    logic                id_uses_rt;
    logic [ADDR_LEN-1:0] id_dest;
    logic [WORD_LEN-1:0] id_imm;
    logic [3:0]          id_alu_op;
    logic                id_reg_write;
    logic                id_mem_read;
    logic                id_mem_write;

    // register file read ports
    logic [ADDR_LEN-1:0] rf_readreg1;
    logic [ADDR_LEN-1:0] rf_readreg2;
    logic [WORD_LEN-1:0] rf_data1;
    logic [WORD_LEN-1:0] rf_data2;

    // writeback port (bypassed onto the read operands)
    logic                wb_write_en;
    logic [ADDR_LEN-1:0] wb_write_reg;
    logic [WORD_LEN-1:0] wb_write_data;

    // pipeline control
    logic                flush;
    logic                ex_hold;
    logic                id_stall;

    // ID/EX register contents
    logic                ex_valid;
    logic [WORD_LEN-1:0] ex_pc;
    logic [WORD_LEN-1:0] ex_op1;
    logic [WORD_LEN-1:0] ex_op2;
    logic [WORD_LEN-1:0] ex_imm;
    logic [ADDR_LEN-1:0] ex_rs;
    logic [ADDR_LEN-1:0] ex_rt;
    logic [ADDR_LEN-1:0] ex_dest;
    logic [3:0]          ex_alu_op;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                ex_mem_write;

    logic [15:0]         bubble_count;

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_uses_rt, id_dest, id_imm,
               id_alu_op, id_reg_write, id_mem_read, id_mem_write,
        output rf_readreg1, rf_readreg2,
        input  rf_data1, rf_data2,
        input  wb_write_en, wb_write_reg, wb_write_data,
        input  flush, ex_hold,
        output id_stall,
        output ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs, ex_rt, ex_dest,
               ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write,
        output bubble_count
    );

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_uses_rt, id_dest, id_imm,
               id_alu_op, id_reg_write, id_mem_read, id_mem_write,
        input  rf_readreg1, rf_readreg2,
        output rf_data1, rf_data2,
        output wb_write_en, wb_write_reg, wb_write_data,
        output flush, ex_hold,
        input  id_stall,
        input  ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs, ex_rt, ex_dest,
               ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write,
        input  bubble_count
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//
// Purpose: operand fetch and ID/EX pipeline register of the pipelined MIPS
// core. Drives the register file read addresses from the decoded rs/rt,
// bypasses same-cycle writeback data onto the read operands, forces $zero to
// read as 0, registers operands and control into execute, and inserts one
// bubble on a load-use hazard while stalling decode. Branch flush and
// downstream hold are honoured; a flush that arrives during hold is remembered
// and applied when hold drops.
//
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous, active-high reset
//   bus  - id_ex_operand_stage_if.slave: decode slot in, register file
//          read addresses out / read data in, writeback port in, flush and
//          ex_hold in, id_stall out, ID/EX register out, bubble_count out
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int WORD_LEN = 32,
    parameter int ADDR_LEN = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_operand_stage_if.slave  bus
);

    localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

    // -------------------------------------------------------------------------
    // Operand select: $zero beats the bypass, the bypass beats the file.
    // The file is written at the same posedge we capture, so without the
    // bypass the operand would be one write stale.
    // -------------------------------------------------------------------------
    function automatic logic [WORD_LEN-1:0] select_operand(
        input logic [ADDR_LEN-1:0] src,
        input logic [WORD_LEN-1:0] file_data,
        input logic                wb_en,
        input logic [ADDR_LEN-1:0] wb_reg,
        input logic [WORD_LEN-1:0] wb_data
    );
        logic [WORD_LEN-1:0] result;
        if (src == '0) begin
            result = '0;
        end else if (wb_en && (wb_reg == src)) begin
            result = wb_data;
        end else begin
            result = file_data;
        end
        return result;
    endfunction

    // -------------------------------------------------------------------------
    // ID/EX register state
    // -------------------------------------------------------------------------
    logic                ex_valid_q;
    logic [WORD_LEN-1:0] ex_pc_q;
    logic [WORD_LEN-1:0] ex_op1_q;
    logic [WORD_LEN-1:0] ex_op2_q;
    logic [WORD_LEN-1:0] ex_imm_q;
    logic [ADDR_LEN-1:0] ex_rs_q;
    logic [ADDR_LEN-1:0] ex_rt_q;
    logic [ADDR_LEN-1:0] ex_dest_q;
    logic [3:0]          ex_alu_op_q;
    logic                ex_reg_write_q;
    logic                ex_mem_read_q;
    logic                ex_mem_write_q;
    logic [15:0]         bubble_count_q;

    // A flush seen while ex_hold froze the register; applied on release.
    logic                pending_flush_q;

    // -------------------------------------------------------------------------
    // Combinational datapath and hazard detection
    // -------------------------------------------------------------------------
    logic [WORD_LEN-1:0] op1_sel;
    logic [WORD_LEN-1:0] op2_sel;
    logic                rs_match;
    logic                rt_match;
    logic                load_use;
    logic                stall;

    always_comb begin
        op1_sel  = select_operand(bus.id_rs, bus.rf_data1, bus.wb_write_en,
                                  bus.wb_write_reg, bus.wb_write_data);
        op2_sel  = select_operand(bus.id_rt, bus.rf_data2, bus.wb_write_en,
                                  bus.wb_write_reg, bus.wb_write_data);

        // rt only counts when the instruction actually reads it; an I-type
        // ALU op names its destination in the rt field.
        rs_match = (ex_dest_q == bus.id_rs);
        rt_match = bus.id_uses_rt && (ex_dest_q == bus.id_rt);

        // A load to $zero produces nothing anyone can depend on.
        load_use = ex_valid_q && ex_mem_read_q && (ex_dest_q != '0) &&
                   bus.id_valid && (rs_match || rt_match);

        // flush kills the decode slot, so its hazard is moot; ex_hold still
        // stalls decode because ID/EX cannot take anything new.
        stall    = (load_use && !bus.flush) || bus.ex_hold;
    end

    // -------------------------------------------------------------------------
    // ID/EX register update, priority: rst, hold, flush, load-use, capture.
    // On flush and bubble the datapath fields are left as they were; only
    // ex_valid and the side-effecting controls matter downstream.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_pc_q         <= '0;
            ex_op1_q        <= '0;
            ex_op2_q        <= '0;
            ex_imm_q        <= '0;
            ex_rs_q         <= '0;
            ex_rt_q         <= '0;
            ex_dest_q       <= '0;
            ex_alu_op_q     <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            bubble_count_q  <= '0;
            pending_flush_q <= 1'b0;
        end else if (bus.ex_hold) begin
            // Everything frozen, bubbles included; only remember a flush.
            pending_flush_q <= pending_flush_q | bus.flush;
        end else if (bus.flush || pending_flush_q) begin
            ex_valid_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            pending_flush_q <= 1'b0;
        end else if (load_use) begin
            // The bubble clears ex_mem_read, so the hazard drops next cycle
            // and exactly one bubble is inserted per load-use.
            ex_valid_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            if (bubble_count_q != BUBBLE_MAX) begin
                bubble_count_q <= bubble_count_q + 16'd1;
            end
        end else begin
            ex_valid_q      <= bus.id_valid;
            ex_pc_q         <= bus.id_pc;
            ex_op1_q        <= op1_sel;
            ex_op2_q        <= op2_sel;
            ex_imm_q        <= bus.id_imm;
            ex_rs_q         <= bus.id_rs;
            ex_rt_q         <= bus.id_rt;
            ex_dest_q       <= bus.id_dest;
            ex_alu_op_q     <= bus.id_alu_op;
            ex_reg_write_q  <= bus.id_reg_write && bus.id_valid;
            ex_mem_read_q   <= bus.id_mem_read  && bus.id_valid;
            ex_mem_write_q  <= bus.id_mem_write && bus.id_valid;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.rf_readreg1  = bus.id_rs;
    assign bus.rf_readreg2  = bus.id_rt;
    assign bus.id_stall     = stall;

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_pc        = ex_pc_q;
    assign bus.ex_op1       = ex_op1_q;
    assign bus.ex_op2       = ex_op2_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_rs        = ex_rs_q;
    assign bus.ex_rt        = ex_rt_q;
    assign bus.ex_dest      = ex_dest_q;
    assign bus.ex_alu_op    = ex_alu_op_q;
    assign bus.ex_reg_write = ex_reg_write_q;
    assign bus.ex_mem_read  = ex_mem_read_q;
    assign bus.ex_mem_write = ex_mem_write_q;
    assign bus.bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_operand_stage
//
// Directed bench for id_ex_operand_stage. The driver issues decode slots and
// pushes the hand-computed ID/EX contents of every instruction that should
// reach execute; a monitor pops and compares whenever ID/EX takes a new valid
// instruction. Stall, bubble and flush behaviour is checked by the driver.
// -----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

    localparam int WORD_LEN = 32;
    localparam int ADDR_LEN = 5;
    localparam int EXP_W    = 4 * WORD_LEN + 3 * ADDR_LEN + 4 + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.WORD_LEN(WORD_LEN), .ADDR_LEN(ADDR_LEN)) bus ();

    id_ex_operand_stage #(.WORD_LEN(WORD_LEN), .ADDR_LEN(ADDR_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a decode slot; when push is set, also queue what ID/EX must hold
    // once it accepts this slot (e1/e2 are the hand-computed operands).
    task automatic issue(input logic v, input logic [31:0] pc,
                         input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic [4:0] dest, input logic [3:0] alu,
                         input logic rw, input logic mr, input logic mw,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic push, input logic [31:0] e1, input logic [31:0] e2);
        logic [31:0] imm;
        imm = pc ^ 32'hA5A5_0000;
        bus.id_valid     = v;
        bus.id_pc        = pc;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_uses_rt   = urt;
        bus.id_dest      = dest;
        bus.id_imm       = imm;
        bus.id_alu_op    = alu;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
        bus.rf_data1     = d1;
        bus.rf_data2     = d2;
        if (push) exp_q.push_back({pc, imm, e1, e2, rs, rt, dest, alu, rw, mr, mw});
    endtask

    task automatic set_wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        bus.wb_write_en   = en;
        bus.wb_write_reg  = r;
        bus.wb_write_data = d;
    endtask

    task automatic randomize_inputs();
        bus.id_valid     = 1'($urandom_range(0, 1));
        bus.id_pc        = $urandom;
        bus.id_rs        = 5'($urandom_range(0, 31));
        bus.id_rt        = 5'($urandom_range(0, 31));
        bus.id_uses_rt   = 1'($urandom_range(0, 1));
        bus.id_dest      = 5'($urandom_range(0, 31));
        bus.id_imm       = $urandom;
        bus.id_alu_op    = 4'($urandom_range(0, 15));
        bus.id_reg_write = 1'($urandom_range(0, 1));
        bus.id_mem_read  = 1'($urandom_range(0, 1));
        bus.id_mem_write = 1'($urandom_range(0, 1));
        bus.rf_data1     = $urandom;
        bus.rf_data2     = $urandom;
        set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        bus.flush        = 1'($urandom_range(0, 1));
        bus.ex_hold      = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic             upd;
        logic [EXP_W-1:0] act;
        logic [EXP_W-1:0] exp;
        forever begin
            @(posedge clk);
            upd = !rst && !bus.ex_hold;
            @(negedge clk);
            if (upd && bus.ex_valid) begin
                act = {bus.ex_pc, bus.ex_imm, bus.ex_op1, bus.ex_op2, bus.ex_rs, bus.ex_rt,
                       bus.ex_dest, bus.ex_alu_op, bus.ex_reg_write, bus.ex_mem_read,
                       bus.ex_mem_write};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got %h want nothing queued", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        bad++;
                        $display("FAIL sb_idex: got %h want %h", act, exp);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin : driver
        rst = 1'b1;
        randomize_inputs();
        tick();
        randomize_inputs();
        tick();
        // two reset edges taken
        check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_ex_pc", bus.ex_pc, 32'd0);
        check("rst_ex_op1", bus.ex_op1, 32'd0);
        check("rst_ex_op2", bus.ex_op2, 32'd0);
        check("rst_ctrl", {29'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 32'd0);
        check("rst_ex_dest", 32'(bus.ex_dest), 32'd0);
        check("rst_bubbles", 32'(bus.bubble_count), 32'd0);
        check("rst_id_stall", 32'(bus.id_stall), 32'd0);

        // pass-through; wb names r3 but is disabled
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.ex_hold = 1'b0;
        set_wb(1'b0, 5'd3, 32'hBAD0_BAD0);
        issue(1, 32'h100, 5'd3, 5'd4, 1, 5'd8, 4'd2, 1, 0, 0, 32'h11, 32'h22, 1, 32'h11, 32'h22);
        #1;
        check("rf_readreg1", 32'(bus.rf_readreg1), 32'd3);
        check("rf_readreg2", 32'(bus.rf_readreg2), 32'd4);
        check("pass_stall", 32'(bus.id_stall), 32'd0);

        // wb bypass onto rs
        tick();
        check("pass_ex_valid", 32'(bus.ex_valid), 32'd1);
        set_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        issue(1, 32'h104, 5'd5, 5'd6, 1, 5'd9, 4'd3, 1, 0, 0, 32'h0, 32'h33, 1, 32'hDEAD_BEEF, 32'h33);

        // $zero reads 0 even when wb targets r0 and the file holds junk
        tick();
        check("byp_ex_op1", bus.ex_op1, 32'hDEAD_BEEF);
        set_wb(1'b1, 5'd0, 32'h5555_5555);
        issue(1, 32'h108, 5'd0, 5'd5, 1, 5'd10, 4'd1, 1, 0, 0, 32'h77, 32'h99, 1, 32'h0, 32'h99);

        // wb bypass onto rt
        tick();
        check("zero_ex_op1", bus.ex_op1, 32'h0);
        set_wb(1'b1, 5'd9, 32'hCAFE_0009);
        issue(1, 32'h10C, 5'd1, 5'd9, 1, 5'd11, 4'd4, 0, 0, 1, 32'h1, 32'h0, 1, 32'h1, 32'hCAFE_0009);

        // load-use: lw r7 then add reading r7
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        issue(1, 32'h110, 5'd2, 5'd7, 0, 5'd7, 4'd0, 1, 1, 0, 32'h40, 32'h0, 1, 32'h40, 32'h0);
        #1;
        check("lw_stall", 32'(bus.id_stall), 32'd0);
        tick();
        issue(1, 32'h114, 5'd7, 5'd3, 1, 5'd9, 4'd2, 1, 0, 0, 32'h1234, 32'h5, 0, 32'h0, 32'h0);
        #1;
        check("lu_stall", 32'(bus.id_stall), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        check("lu_bubbles", 32'(bus.bubble_count), 32'd1);
        issue(1, 32'h114, 5'd7, 5'd3, 1, 5'd9, 4'd2, 1, 0, 0, 32'h1234, 32'h5, 1, 32'h1234, 32'h5);
        #1;
        check("lu_release", 32'(bus.id_stall), 32'd0);

        // load to r0 followed by a reader of r0: no hazard
        tick();
        check("lu_issue_pc", bus.ex_pc, 32'h114);
        issue(1, 32'h118, 5'd2, 5'd0, 0, 5'd0, 4'd0, 1, 1, 0, 32'h8, 32'h0, 1, 32'h8, 32'h0);
        tick();
        issue(1, 32'h11C, 5'd0, 5'd0, 1, 5'd12, 4'd2, 1, 0, 0, 32'hFFFF, 32'hEEEE, 1, 32'h0, 32'h0);
        #1;
        check("r0_no_stall", 32'(bus.id_stall), 32'd0);

        // flush together with a load-use hazard: flush wins, no bubble counted
        tick();
        check("r0_bubbles", 32'(bus.bubble_count), 32'd1);
        issue(1, 32'h120, 5'd2, 5'd7, 0, 5'd7, 4'd0, 1, 1, 0, 32'h44, 32'h0, 1, 32'h44, 32'h0);
        tick();
        issue(1, 32'h124, 5'd1, 5'd7, 1, 5'd9, 4'd2, 1, 0, 0, 32'h1, 32'h2, 0, 32'h0, 32'h0);
        bus.flush = 1'b1;
        #1;
        check("flush_mask_stall", 32'(bus.id_stall), 32'd0);
        tick();
        check("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("flush_bubbles", 32'(bus.bubble_count), 32'd1);
        bus.flush = 1'b0;

        // hold three cycles with a flush arriving during the hold
        issue(1, 32'h130, 5'd1, 5'd2, 1, 5'd13, 4'd5, 1, 0, 0, 32'hA1, 32'hB2, 1, 32'hA1, 32'hB2);
        tick();
        bus.ex_hold = 1'b1;
        issue(1, 32'h134, 5'd3, 5'd4, 1, 5'd14, 4'd6, 1, 0, 0, 32'hC3, 32'hD4, 0, 32'h0, 32'h0);
        #1;
        check("hold_stall", 32'(bus.id_stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_ex_pc", bus.ex_pc, 32'h130);
            check("hold_ex_op1", bus.ex_op1, 32'hA1);
            check("hold_ex_valid", 32'(bus.ex_valid), 32'd1);
            bus.flush = (i == 0);
        end
        bus.ex_hold = 1'b0;
        issue(1, 32'h138, 5'd3, 5'd4, 1, 5'd14, 4'd6, 1, 0, 0, 32'hC3, 32'hD4, 0, 32'h0, 32'h0);
        tick();
        check("pend_flush_valid", 32'(bus.ex_valid), 32'd0);
        issue(1, 32'h13C, 5'd3, 5'd4, 1, 5'd14, 4'd6, 1, 0, 0, 32'hC3, 32'hD4, 1, 32'hC3, 32'hD4);

        // hold together with a load-use hazard: hold first, then one bubble
        tick();
        check("after_pend_valid", 32'(bus.ex_valid), 32'd1);
        issue(1, 32'h140, 5'd2, 5'd7, 0, 5'd7, 4'd0, 1, 1, 0, 32'h48, 32'h0, 1, 32'h48, 32'h0);
        tick();
        bus.ex_hold = 1'b1;
        issue(1, 32'h144, 5'd1, 5'd7, 1, 5'd9, 4'd2, 1, 0, 0, 32'h3, 32'h4, 0, 32'h0, 32'h0);
        #1;
        check("hh_stall_hold", 32'(bus.id_stall), 32'd1);
        tick();
        check("hh_held_pc", bus.ex_pc, 32'h140);
        check("hh_bubbles_hold", 32'(bus.bubble_count), 32'd1);
        bus.ex_hold = 1'b0;
        #1;
        check("hh_stall_hazard", 32'(bus.id_stall), 32'd1);
        tick();
        check("hh_bubble_valid", 32'(bus.ex_valid), 32'd0);
        check("hh_bubbles", 32'(bus.bubble_count), 32'd2);
        issue(1, 32'h144, 5'd1, 5'd7, 1, 5'd9, 4'd2, 1, 0, 0, 32'h3, 32'h4, 1, 32'h3, 32'h4);
        #1;
        check("hh_release", 32'(bus.id_stall), 32'd0);

        // reset in the middle of a load-use stall
        tick();
        issue(1, 32'h150, 5'd2, 5'd7, 0, 5'd7, 4'd0, 1, 1, 0, 32'h4C, 32'h0, 1, 32'h4C, 32'h0);
        tick();
        issue(1, 32'h154, 5'd7, 5'd1, 1, 5'd9, 4'd2, 1, 0, 0, 32'h5, 32'h6, 0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(bus.ex_valid), 32'd0);
        check("mid_rst_bubbles", 32'(bus.bubble_count), 32'd0);
        check("mid_rst_stall", 32'(bus.id_stall), 32'd0);
        rst = 1'b0;
        bus.id_valid = 1'b0;
        tick();
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Operand-fetch and ID/EX pipeline register for the pipelined MIPS core. Sits between decode and execute, directly downstream of the register file. Drives the file's read addresses from the decoded rs/rt, and bypasses same-cycle writeback data onto the read operands. Registers operands and control into the execute stage, and detects load-use hazards, inserting one bubble and stalling decode. Also honours branch flush and downstream hold.

## Interface
- WORD_LEN, 32, datapath width
- ADDR_LEN, 5, register address width (32 registers)
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  decode slot holds a real instruction
- id_pc  input  WORD_LEN  PC of decode instruction
- id_rs, id_rt  input  ADDR_LEN  source register numbers
- id_uses_rt  input  1  instruction reads rt (R-type, store, branch)
- id_dest  input  ADDR_LEN  destination register
- id_imm  input  WORD_LEN  sign/zero-extended immediate
- id_alu_op  input  4  ALU operation code
- id_reg_write, id_mem_read, id_mem_write  input  1 each  control bits
- rf_readreg1, rf_readreg2  output  ADDR_LEN  = id_rs, id_rt (combinational)
- rf_data1, rf_data2  input  WORD_LEN  register file read data
- wb_write_en  input  1  writeback write enable
- wb_write_reg  input  ADDR_LEN  writeback destination
- wb_write_data  input  WORD_LEN  writeback data
- flush  input  1  branch/jump resolved taken; kill decode slot
- ex_hold  input  1  execute stage cannot accept; freeze ID/EX
- id_stall  output  1  decode must hold PC and IF/ID (combinational)
- ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs, ex_rt, ex_dest, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write  output  registered copies
- bubble_count  output  16  saturating count of load-use bubbles

## Operation
- Operand select for op1, applied the same way to op2 with rt:
  - rs == 0 → 0.
  - Otherwise, wb_write_en && wb_write_reg == rs → wb_write_data.
  - Otherwise → rf_data1.
- Load-use hazard: ex_valid && ex_mem_read && ex_dest != 0 && id_valid && (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt)).
- id_stall = load-use hazard OR ex_hold. flush masks the hazard term (not ex_hold).
- Register update priority on each posedge, highest first:
  1. rst: all ex_* outputs and bubble_count ← 0.
  2. ex_hold: all ex_* registers keep their value, including a bubble. flush during hold is not lost: ex_valid and controls are cleared when hold drops, via a 1-bit pending_flush register.
  3. flush, or pending_flush set: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write ← 0; datapath fields don't-care; pending_flush ← 0.
  4. Load-use hazard: insert bubble (ex_valid and three control bits ← 0); bubble_count += 1, saturating at 0xFFFF.
  5. Otherwise capture decode fields and selected operands. ex_valid ← id_valid. Control bits are ANDed with id_valid.
- Exactly one bubble per load-use. Next cycle ex_mem_read = 0, so the hazard clears and decode proceeds.
- Register 0 is never a hazard source and always reads 0, regardless of file contents.

## Timing
- Latency: decode inputs to ex_* outputs is one clock.
- rf_readreg* and id_stall are combinational, same cycle.
- WB bypass is same-cycle combinational. The value written at a posedge is visible in the ex_op captured at that same posedge.
- All ex_* outputs are 0 and id_stall is 0 in the cycle after reset asserts (id_stall re-evaluates from zeroed ex_*).
- Reset mid-stall: the bubble and pending_flush are discarded, and bubble_count clears.
- Simultaneous flush + hazard: flush wins; no bubble is counted.
- Simultaneous hold + hazard: hold wins. The hazard re-evaluates after release and is counted once.

## Test plan
- Reset: assert rst 2 cycles with random inputs → all ex_* = 0, bubble_count = 0, id_stall = 0.
- Pass-through: id_valid=1, rs=3, rt=4, rf_data1=0x11, rf_data2=0x22, no WB → next cycle ex_op1=0x11, ex_op2=0x22, ex_valid=1.
- WB bypass and $zero:
  - rs=5, wb_write_en=1, wb_write_reg=5, wb_data=0xDEADBEEF, rf_data1=0 → ex_op1=0xDEADBEEF.
  - rs=0 with wb_write_reg=0 → ex_op1=0.
- Load-use: lw to r7 in EX, then add reading r7 in ID → id_stall=1 for exactly 1 cycle, ex_valid=0 for that cycle, bubble_count=1. The add issues next cycle. Same case with dest r0 → no stall.
- Flush and hold interaction:
  - flush with hazard → ex_valid=0, bubble_count unchanged.
  - ex_hold held 3 cycles → ex_* stable.
  - flush asserted during hold → ex_valid=0 in the cycle after hold drops.
